// File: rtl/dmem_txn_fifo.sv
// dmem_txn_fifo: first-word-fall-through buffer of data-memory bus accesses.
// Each accepted capture is stored as (direction, address, byte-masked data,
// byte enables). A consumer drains the head through out_valid/out_ready.
// Captures that arrive while the buffer is full and not being popped are
// dropped and accounted in a sticky overflow flag and a saturating counter.
// Optional feature macro: DMEM_TXN_TS_EN adds a 32-bit free-running cycle
// counter whose value in the capture cycle is stored with each entry and
// presented on out_ts.
module dmem_txn_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cap_valid,
   input  logic                       cap_we,
   input  logic [ADDR_W-1:0]          cap_addr,
   input  logic [DATA_W-1:0]          cap_data,
   input  logic [DATA_W/8-1:0]        cap_be,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_dir,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [DATA_W-1:0]          out_data,
   output logic [DATA_W/8-1:0]        out_be,
`ifdef DMEM_TXN_TS_EN
   output logic [31:0]                out_ts,
`endif
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic                       ovf_clr
);

   localparam int BE_W  = DATA_W / 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

   // Zero every byte lane whose enable is low.
   function automatic logic [DATA_W-1:0] f_mask_bytes(
      input logic [DATA_W-1:0] data,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] masked;
      masked = {DATA_W{1'b0}};
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) begin
            masked[8*i +: 8] = data[8*i +: 8];
         end else begin
            masked[8*i +: 8] = 8'h00;
         end
      end
      return masked;
   endfunction

   // Entry storage (not reset: contents are only observed while out_valid).
   logic                r_mem_dir  [DEPTH];
   logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
   logic [DATA_W-1:0]   r_mem_data [DEPTH];
   logic [BE_W-1:0]     r_mem_be   [DEPTH];
`ifdef DMEM_TXN_TS_EN
   logic [31:0]         r_mem_ts   [DEPTH];
   logic [31:0]         r_ts_cnt;
`endif

   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [OCC_W-1:0]    r_count;
   logic                r_overflow;
   logic [CNT_W-1:0]    r_drop_cnt;

   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;

   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == {OCC_W{1'b0}});
   // A pop frees the head slot in the same cycle, so a full buffer still
   // accepts a capture when the consumer is draining.
   assign w_pop   = !w_empty && out_ready;
   assign w_push  = cap_valid && (!w_full || w_pop);
   assign w_drop  = cap_valid && w_full && !w_pop;

   // Advance read/write pointers and track occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {OCC_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Write the masked capture record into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem_dir[r_wr_ptr]  <= cap_we;
         r_mem_addr[r_wr_ptr] <= cap_addr;
         r_mem_data[r_wr_ptr] <= f_mask_bytes(cap_data, cap_be);
         r_mem_be[r_wr_ptr]   <= cap_be;
`ifdef DMEM_TXN_TS_EN
         r_mem_ts[r_wr_ptr]   <= r_ts_cnt;
`endif
      end
   end

   // Sticky overflow flag and saturating drop counter; a drop outranks a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= {CNT_W{1'b0}};
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (ovf_clr) begin
            r_drop_cnt <= CNT_W'(1);
         end else if (r_drop_cnt != DROP_MAX) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end else begin
            r_drop_cnt <= r_drop_cnt;
         end
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= {CNT_W{1'b0}};
      end else begin
         r_overflow <= r_overflow;
         r_drop_cnt <= r_drop_cnt;
      end
   end

`ifdef DMEM_TXN_TS_EN
   // Free-running cycle counter sampled into each entry at capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts_cnt <= 32'd0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 32'd1;
      end
   end

   assign out_ts = r_mem_ts[r_rd_ptr];
`endif

   assign out_valid = !w_empty;
   assign out_dir   = r_mem_dir[r_rd_ptr];
   assign out_addr  = r_mem_addr[r_rd_ptr];
   assign out_data  = r_mem_data[r_rd_ptr];
   assign out_be    = r_mem_be[r_rd_ptr];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dmem_txn_fifo.sv
// Self-checking bench for dmem_txn_fifo: table-driven vectors plus
// hand-written sequences, with a queue scoreboard of expected head records.
module tb_dmem_txn_fifo;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int DEP = 8;
   localparam int CW  = 4;   // small drop counter so saturation is reachable

   logic          clk = 1'b0;
   logic          rst;
   logic          cap_valid, cap_we;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_data;
   logic [3:0]    cap_be;
   logic          out_valid, out_ready, out_dir;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic [3:0]    out_be;
`ifdef DMEM_TXN_TS_EN
   logic [31:0]   out_ts;
`endif
   logic [3:0]    count;
   logic          full, empty, overflow, ovf_clr;
   logic [CW-1:0] drop_cnt;

   always #5 clk = ~clk;

   dmem_txn_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cap_valid(cap_valid), .cap_we(cap_we), .cap_addr(cap_addr),
      .cap_data(cap_data), .cap_be(cap_be),
      .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
      .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
`ifdef DMEM_TXN_TS_EN
      .out_ts(out_ts),
`endif
      .count(count), .full(full), .empty(empty),
      .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
   );

   typedef struct {
      logic        v;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        rdy;
      logic        clr;
      int          exp_cnt;
      int          exp_dc;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } rec_t;

   rec_t  sb[$];
   int    m_dc;
   logic  m_ovf;
   int    n_err = 0;
   int    n_chk = 0;
   vec_t  tbl[7];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mdl_mask(input logic [31:0] d, input logic [3:0] be);
      return d & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic do_reset();
      rst = 1'b1; cap_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      cap_we = 1'b0; cap_addr = 32'd0; cap_data = 32'd0; cap_be = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      m_dc = 0;
      m_ovf = 1'b0;
   endtask

   task automatic check_state();
      chk("count", 64'(count), 64'(sb.size()));
      chk("full", 64'(full), 64'(sb.size() == DEP));
      chk("empty", 64'(empty), 64'(sb.size() == 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_dc));
   endtask

   // One cycle: drive inputs, check head at negedge, update model after edge.
   task automatic drive(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic rdy, input logic clr);
      logic pop, push, drop;
      rec_t r;
      cap_valid = v; cap_we = we; cap_addr = a; cap_data = d; cap_be = be;
      out_ready = rdy; ovf_clr = clr;
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk("out_dir", 64'(out_dir), 64'(sb[0].we));
         chk("out_addr", 64'(out_addr), 64'(sb[0].a));
         chk("out_data", 64'(out_data), 64'(sb[0].d));
         chk("out_be", 64'(out_be), 64'(sb[0].be));
      end
      pop  = (sb.size() != 0) && rdy;
      push = v && ((sb.size() < DEP) || pop);
      drop = v && (sb.size() == DEP) && !pop;
      @(posedge clk);
      #1;
      if (pop) void'(sb.pop_front());
      if (push) begin
         r.we = we; r.a = a; r.d = mdl_mask(d, be); r.be = be;
         sb.push_back(r);
      end
      if (drop) begin
         m_ovf = 1'b1;
         m_dc = clr ? 1 : ((m_dc == 15) ? 15 : m_dc + 1);
      end else if (clr) begin
         m_ovf = 1'b0;
         m_dc = 0;
      end
      check_state();
      cap_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1, 0};
      tbl[1] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 0, 0};
      tbl[2] = '{1'b1, 1'b0, 32'h104, 32'h11223344, 4'h5, 1'b0, 1'b0, 1, 0};
      tbl[3] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 0, 0};
      tbl[4] = '{1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'hC, 1'b1, 1'b0, 1, 0};
      tbl[5] = '{1'b1, 1'b0, 32'h204, 32'h01020304, 4'h3, 1'b1, 1'b0, 1, 0};
      tbl[6] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 0, 0};

      do_reset();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

`ifdef DMEM_TXN_TS_EN
      // Captures in cycles 3 and 7 after reset release.
      for (int k = 0; k < 8; k++) begin
         drive((k == 3) || (k == 7), 1'b1, 32'h40 + 32'(k), 32'h0 + 32'(k), 4'hF, 1'b0, 1'b0);
      end
      chk("ts_first", 64'(out_ts), 64'd3);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      chk("ts_second", 64'(out_ts), 64'd7);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
`endif

      // Table: single write, masking, push into empty, push+pop at count 1.
      for (int i = 0; i < 7; i++) begin
         if (i == 1) begin
            chk("write_data", 64'(out_data), 64'hDEADBEEF);
            chk("write_addr", 64'(out_addr), 64'h100);
         end
         if (i == 3) chk("mask_data", 64'(out_data), 64'h00220044);
         drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].rdy, tbl[i].clr);
         chk("tbl_count", 64'(count), 64'(tbl[i].exp_cnt));
         chk("tbl_drop_cnt", 64'(drop_cnt), 64'(tbl[i].exp_dc));
      end

      // Fill with 10 captures while the consumer stalls.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'(i), 32'h300 + 32'(4 * i), $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_count", 64'(count), 64'd8);
      chk("fill_overflow", 64'(overflow), 64'd1);
      chk("fill_drop_cnt", 64'(drop_cnt), 64'd2);

      // Push and pop together while full: no drop, new record comes last.
      drive(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
      chk("pp_count", 64'(count), 64'd8);
      chk("pp_drop_cnt", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("pp_last_addr", 64'(out_addr), 64'h400);
         drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      end
      chk("drain_empty", 64'(empty), 64'd1);

      // Clear in the same cycle as a drop: drop wins.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'h500 + 32'(i), $urandom, 4'hF, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b0, 32'h600, 32'h12345678, 4'hF, 1'b0, 1'b1);
      chk("clr_drop_ovf", 64'(overflow), 64'd1);
      chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("clr_ovf", 64'(overflow), 64'd0);
      chk("clr_cnt", 64'(drop_cnt), 64'd0);

      // Drop counter saturation.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, 32'h700, 32'h0, 4'hF, 1'b0, 1'b0);
      end
      chk("sat_drop_cnt", 64'(drop_cnt), 64'd15);

      // Reset during operation with push and pop requested: all discarded.
      rst = 1'b1; cap_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
      sb.delete(); m_dc = 0; m_ovf = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check_state();
      drive(1'b1, 1'b0, 32'h800, 32'hFFFF0000, 4'hA, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_txn_fifo.md
# dmem_txn_fifo

Parametrised data-memory transaction buffer for the SOIN-RV verification environment. It sits on the core's data-memory bus and captures every load/store as an (address, data, direction, byte-enable) record into a first-word-fall-through FIFO. A scoreboard or monitor drains the FIFO through a valid/ready port. It generalises the single `data_item_t` record (data, addr, direction) to configurable widths and depth, and adds byte-enable masking, overflow accounting and optional timestamps.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits; multiple of 8.
- `ADDR_W`, 32: address width in bits.
- `DEPTH`, 8: FIFO entries; power of 2, ≥2.
- `CNT_W`, 16: width of the drop counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `cap_valid`  in  1  bus access present this cycle.
- `cap_we`  in  1  direction: 0 = READ, 1 = WRITE.
- `cap_addr`  in  ADDR_W  access address.
- `cap_data`  in  DATA_W  write data or read-return data.
- `cap_be`  in  DATA_W/8  byte enables.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_dir`  out  1  head direction.
- `out_addr`  out  ADDR_W  head address.
- `out_data`  out  DATA_W  head data, masked by `out_be`.
- `out_be`  out  DATA_W/8  head byte enables.
- `out_ts`  out  32  head timestamp (only with `DMEM_TXN_TS_EN`).
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `full`, `empty`  out  1  occupancy flags.
- `overflow`  out  1  sticky; a capture was dropped.
- `drop_cnt`  out  CNT_W  dropped captures, saturating.
- `ovf_clr`  in  1  clears `overflow` and `drop_cnt`.

## Operation
- Storage: DEPTH-entry circular buffer, write pointer, read pointer, `count` register.
- Push: `cap_valid && (!full || pop)`, where `pop = out_valid && out_ready`. Writes one entry at the write pointer and increments it mod DEPTH.
- Stored data is masked at capture: byte i = `cap_data[8i+7:8i]` when `cap_be[i]`, otherwise 0x00.
- Pop: `pop` increments the read pointer mod DEPTH.
- Simultaneous push and pop:
  - count unchanged.
  - Legal when full: the entry is freed and refilled in the same cycle.
  - Legal when empty: the new entry is written and the next cycle presents it; no bypass in the same cycle.
- Drop: `cap_valid && full && !pop` discards the capture.
  - Sets `overflow`.
  - Increments `drop_cnt`, saturating at 2^CNT_W−1.
- `ovf_clr`:
  - Clears `overflow` and `drop_cnt`.
  - If a drop occurs in the same cycle, the drop wins: `overflow` = 1, `drop_cnt` = 1.
- Output signals:
  - `out_*` are driven combinationally from the entry at the read pointer.
  - `out_valid = !empty`.
  - `out_*` values are don't-care while `out_valid` = 0.
- Flags: `full = (count == DEPTH)`, `empty = (count == 0)`.
- Handshake: once `out_valid` = 1, the head entry stays stable until popped.

## Timing
- Reset values:
  - Pointers and `count` = 0.
  - `empty` = 1, `full` = 0, `out_valid` = 0.
  - `overflow` = 0, `drop_cnt` = 0, timestamp counter = 0.
- Reset during operation discards all entries on the next edge; a push or pop in the reset cycle is ignored.
- Latency: capture at edge N → `out_valid` high after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle sustained.
- Pointer wrap: entry DEPTH−1 is followed by entry 0, with no bubble.

## Configuration
- `DMEM_TXN_TS_EN` defined:
  - A 32-bit free-running cycle counter (reset 0, wraps at 2^32) is sampled into each entry at push.
  - The value stored is the counter value in the capture cycle, and is presented on `out_ts`.
- `DMEM_TXN_TS_EN` undefined:
  - No counter and no timestamp storage.
  - The `out_ts` port is absent.

## Test plan
- Reset, then a single WRITE:
  - Stimulus: `cap_addr` 0x100, `cap_data` 0xDEADBEEF, `cap_be` 0xF.
  - Required: `out_valid` next cycle with dir 1, addr 0x100, data 0xDEADBEEF; `count` 1.
- Masking:
  - Stimulus: READ with `cap_data` 0x11223344, `cap_be` 0x5.
  - Required: `out_data` 0x00220044.
- Fill and overflow (DEPTH=8, `out_ready` 0):
  - Stimulus: 10 captures.
  - Required: `full`, `count` 8, `overflow` 1, `drop_cnt` 2; draining returns the first 8 records in order.
- Full with simultaneous push and pop:
  - Required: no drop; `count` stays 8; the new record is returned last.
- `ovf_clr` asserted in the same cycle as a drop:
  - Required: `overflow` 1, `drop_cnt` 1.
- With `DMEM_TXN_TS_EN`:
  - Stimulus: captures at cycles 3 and 7 after reset release.
  - Required: `out_ts` values 3 and 7.
